// File: rtl/counter_display_if.sv
// Display-side signal bundle for counter_display: the upstream counter's
// value and carry coming in, and the multiplexed 7-segment drive going out.
interface counter_display_if;
    logic [3:0] q;
    logic       qcc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       wrap;
    logic       q_err;

    // The upstream counter / stimulus side drives q and qcc.
    modport master (
        output q,
        output qcc,
        input  an,
        input  seg,
        input  dp,
        input  wrap,
        input  q_err
    );

    // The display controller consumes q and qcc and drives the display.
    modport slave (
        input  q,
        input  qcc,
        output an,
        output seg,
        output dp,
        output wrap,
        output q_err
    );
endinterface

// File: rtl/counter_display.sv
// Four-digit multiplexed 7-segment display controller.
// Digit 0 shows the (filtered) upstream counter value in hex, digit 1 is blank,
// and digits 2/3 show a two-digit BCD count of rising edges on the upstream carry.
// Both q and qcc are asynchronous to clk and are synchronized before use.
module counter_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             clr,
    counter_display_if.slave bus
);

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

    // Two-flop synchronizers and one extra history stage for each input
    logic [3:0] q_s1;
    logic [3:0] q_s2;
    logic [3:0] q_prev;
    logic       c_s1;
    logic       c_s2;
    logic       c_prev;

    // Counts the cycles since reset release until the history stages hold
    // real samples; comparisons against reset zeros would otherwise look valid
    logic [1:0] fill;
    logic       sync_ready;

    logic [3:0] q_hold;
    logic       q_err_r;
    logic       q_stable;
    logic       q_bad;

    logic       carry_rise;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       wrap_r;

    logic [15:0] prescaler;
    logic [1:0]  digit;

    logic [3:0] cur_val;
    logic       cur_blank;
    logic       cur_dp_on;

    logic [3:0] an_r;
    logic [6:0] seg_r;
    logic       dp_r;

    // Hex font, segments ordered {g,f,e,d,c,b,a}, active-low
    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] f;
        case (v)
            4'h0:    f = 7'b1000000;
            4'h1:    f = 7'b1111001;
            4'h2:    f = 7'b0100100;
            4'h3:    f = 7'b0110000;
            4'h4:    f = 7'b0011001;
            4'h5:    f = 7'b0010010;
            4'h6:    f = 7'b0000010;
            4'h7:    f = 7'b1111000;
            4'h8:    f = 7'b0000000;
            4'h9:    f = 7'b0010000;
            4'hA:    f = 7'b0001000;
            4'hB:    f = 7'b0000011;
            4'hC:    f = 7'b1000110;
            4'hD:    f = 7'b0100001;
            4'hE:    f = 7'b0000110;
            default: f = 7'b0001110;
        endcase
        return f;
    endfunction

    // Bring q and qcc into the clk domain and keep one cycle of history
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_s1   <= 4'd0;
            q_s2   <= 4'd0;
            q_prev <= 4'd0;
            c_s1   <= 1'b0;
            c_s2   <= 1'b0;
            c_prev <= 1'b0;
        end else begin
            q_s1   <= bus.q;
            q_s2   <= q_s1;
            q_prev <= q_s2;
            c_s1   <= bus.qcc;
            c_s2   <= c_s1;
            c_prev <= c_s2;
        end
    end

    // Track how far genuine samples have propagated since reset release
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            fill <= 2'd0;
        end else if (fill != 2'd3) begin
            fill <= fill + 2'd1;
        end
    end

    assign sync_ready = (fill == 2'd3);

    // q only counts once two consecutive synchronized samples agree, which
    // hides bit skew between the individually synchronized q bits
    assign q_stable   = sync_ready && (q_s2 == q_prev);
    assign q_bad      = (q_s2 < 4'd2) || (q_s2 > 4'd9);

    // A carry level already high at reset release is not treated as an edge
    assign carry_rise = sync_ready && c_s2 && !c_prev;

    // Hold the last stable q value and flag any stable value outside 2..9
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_hold  <= 4'd2;
            q_err_r <= 1'b0;
        end else if (q_stable) begin
            q_hold <= q_s2;
            if (q_bad) begin
                q_err_r <= 1'b1;
            end
        end
    end

    // Two-digit BCD count of carry rising edges, sticky wrap on 99 -> 00
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ones   <= 4'd0;
            tens   <= 4'd0;
            wrap_r <= 1'b0;
        end else if (carry_rise) begin
            if (ones == 4'd9) begin
                ones <= 4'd0;
                if (tens == 4'd9) begin
                    tens   <= 4'd0;
                    wrap_r <= 1'b1;
                end else begin
                    tens <= tens + 4'd1;
                end
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

    // Scan prescaler: each digit stays lit for SCAN_DIV clk cycles
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            prescaler <= 16'd0;
            digit     <= 2'd0;
        end else if (prescaler == PRESC_LAST) begin
            prescaler <= 16'd0;
            digit     <= digit + 2'd1;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    // Select what the current digit shows and whether its decimal point is lit
    always_comb begin
        cur_val   = q_hold;
        cur_blank = 1'b0;
        cur_dp_on = 1'b0;
        case (digit)
            2'd0: begin
                cur_val   = q_hold;
                cur_dp_on = q_err_r;
            end
            2'd1: begin
                cur_blank = 1'b1;
            end
            2'd2: begin
                cur_val = ones;
            end
            default: begin
                cur_val   = tens;
                cur_dp_on = wrap_r;
            end
        endcase
    end

    // Registered display drive so anodes and segments switch glitch-free together
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            an_r  <= 4'b1111;
            seg_r <= 7'b1111111;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= ~(4'b0001 << digit);
            seg_r <= cur_blank ? 7'b1111111 : hex_font(cur_val);
            dp_r  <= ~cur_dp_on;
        end
    end

    assign bus.an    = an_r;
    assign bus.seg   = seg_r;
    assign bus.dp    = dp_r;
    assign bus.wrap  = wrap_r;
    assign bus.q_err = q_err_r;

endmodule

// File: tb/tb_counter_display.sv
// Directed bench for counter_display with a short scan period.
module tb_counter_display;

    logic clk;
    logic clr;
    int   total;
    int   bad;

    counter_display_if bus ();

    counter_display #(
        .SCAN_DIV(4)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n clk cycles; the bench drives and samples on falling edges
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the upstream counter value and carry
    task automatic applyStimulus(input logic [3:0] qv, input logic cv);
        bus.q   = qv;
        bus.qcc = cv;
    endtask

    // One comparison of an observed value against its hand-computed value
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
            $error("[TB] check %s differs", tag);
        end
    endtask

    // Wait (bounded) until the given anode pattern is active, then record it
    task automatic waitForAn(input logic [3:0] target, input string tag);
        int k;
        k = 0;
        while (bus.an !== target && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput(tag, 32'(bus.an), 32'(target));
    endtask

    // One single-clk carry pulse followed by five idle clks
    task automatic carryPulse(input logic [3:0] qv);
        applyStimulus(qv, 1'b1);
        tick(1);
        applyStimulus(qv, 1'b0);
        tick(5);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr   = 1'b1;
        applyStimulus(4'd5, 1'b0);
        #2 clr = 1'b0;
        tick(3);

        // Reset values
        checkOutput("rst_an", 32'(bus.an), 32'h0F);
        checkOutput("rst_seg", 32'(bus.seg), 32'h7F);
        checkOutput("rst_dp", 32'(bus.dp), 32'd1);
        checkOutput("rst_wrap", 32'(bus.wrap), 32'd0);
        checkOutput("rst_qerr", 32'(bus.q_err), 32'd0);

        // First clk after release shows digit 0 with the reset q_hold of 2
        clr = 1'b1;
        tick(1);
        checkOutput("rel_an", 32'(bus.an), 32'b1110);
        checkOutput("rel_seg", 32'(bus.seg), 32'b0100100);

        // Scan rotation every 4 clk; the second digit-0 window shows q=5
        tick(4);
        checkOutput("rot1_an", 32'(bus.an), 32'b1101);
        checkOutput("rot1_seg", 32'(bus.seg), 32'b1111111);
        tick(4);
        checkOutput("rot2_an", 32'(bus.an), 32'b1011);
        checkOutput("rot2_seg", 32'(bus.seg), 32'b1000000);
        tick(4);
        checkOutput("rot3_an", 32'(bus.an), 32'b0111);
        checkOutput("rot3_seg", 32'(bus.seg), 32'b1000000);
        checkOutput("rot3_dp", 32'(bus.dp), 32'd1);
        tick(4);
        checkOutput("rot0_an", 32'(bus.an), 32'b1110);
        checkOutput("q5_seg", 32'(bus.seg), 32'b0010010);

        // Twelve carry pulses -> count 12
        for (int i = 0; i < 12; i++) carryPulse(4'd5);
        tick(6);
        waitForAn(4'b1011, "c12_an2");
        checkOutput("c12_ones", 32'(bus.seg), 32'b0100100);
        waitForAn(4'b0111, "c12_an3");
        checkOutput("c12_tens", 32'(bus.seg), 32'b1111001);
        checkOutput("c12_wrap", 32'(bus.wrap), 32'd0);

        // 88 more pulses -> 100 total, count wraps to 00
        for (int i = 0; i < 88; i++) carryPulse(4'd5);
        tick(6);
        checkOutput("c100_wrap", 32'(bus.wrap), 32'd1);
        waitForAn(4'b0111, "c100_an3");
        checkOutput("c100_tens", 32'(bus.seg), 32'b1000000);
        checkOutput("c100_dp3", 32'(bus.dp), 32'd0);
        waitForAn(4'b1011, "c100_an2");
        checkOutput("c100_ones", 32'(bus.seg), 32'b1000000);
        checkOutput("c100_dp2", 32'(bus.dp), 32'd1);

        // A carry held high for 50 clk adds exactly one
        applyStimulus(4'd5, 1'b1);
        tick(50);
        applyStimulus(4'd5, 1'b0);
        tick(6);
        waitForAn(4'b1011, "long_an2");
        checkOutput("long_ones", 32'(bus.seg), 32'b1111001);
        waitForAn(4'b0111, "long_an3");
        checkOutput("long_tens", 32'(bus.seg), 32'b1000000);

        // q = 9 stable, then a one-clk skew glitch 9 -> B -> 2
        applyStimulus(4'd9, 1'b0);
        tick(6);
        waitForAn(4'b1110, "q9_an");
        checkOutput("q9_seg", 32'(bus.seg), 32'b0010000);
        applyStimulus(4'hB, 1'b0);
        tick(1);
        applyStimulus(4'd2, 1'b0);
        tick(8);
        checkOutput("glitch_qerr", 32'(bus.q_err), 32'd0);
        waitForAn(4'b1110, "q2_an");
        checkOutput("q2_seg", 32'(bus.seg), 32'b0100100);
        checkOutput("q2_dp", 32'(bus.dp), 32'd1);

        // Stable out-of-range q = 12 sets q_err and shows C with dp lit
        applyStimulus(4'd12, 1'b0);
        tick(8);
        checkOutput("q12_qerr", 32'(bus.q_err), 32'd1);
        waitForAn(4'b1110, "q12_an");
        checkOutput("q12_seg", 32'(bus.seg), 32'b1000110);
        checkOutput("q12_dp", 32'(bus.dp), 32'd0);

        // Reset two clk after a carry rise: the edge must be abandoned
        applyStimulus(4'd12, 1'b1);
        tick(1);
        applyStimulus(4'd12, 1'b0);
        tick(1);
        clr = 1'b0;
        tick(1);
        checkOutput("mid_an", 32'(bus.an), 32'h0F);
        checkOutput("mid_seg", 32'(bus.seg), 32'h7F);
        checkOutput("mid_dp", 32'(bus.dp), 32'd1);
        checkOutput("mid_wrap", 32'(bus.wrap), 32'd0);
        checkOutput("mid_qerr", 32'(bus.q_err), 32'd0);
        tick(1);
        clr = 1'b1;
        tick(1);
        checkOutput("rel2_an", 32'(bus.an), 32'b1110);
        checkOutput("rel2_seg", 32'(bus.seg), 32'b0100100);
        tick(6);
        waitForAn(4'b1011, "rel2_an2");
        checkOutput("rel2_ones", 32'(bus.seg), 32'b1000000);
        waitForAn(4'b0111, "rel2_an3");
        checkOutput("rel2_tens", 32'(bus.seg), 32'b1000000);
        checkOutput("rel2_dp3", 32'(bus.dp), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
